// File: rtl/led_scan_capture_if.sv
// led_scan_capture_if
// Bundles the sampled display buses and the rebuilt digit fields.
//   led_out     : segment bus as seen on the header, active-low (bit0=a .. bit6=g, bit7=dp)
//   led_sel     : digit select, active-low one-cold
//   digit_code  : nibble i = decoded hex value of digit i
//   digit_blank : digit i last captured with a-g all off
//   digit_err   : digit i last captured with a non-hex glyph
//   digit_dp    : dp of digit i lit at last capture
//   frame_done  : one-cycle pulse, all 8 digits captured since previous pulse
//   sel_err     : one-cycle pulse, stable select had two or more zeros
// master drives the display buses (scanner side); slave is the capture block.
interface led_scan_capture_if;
    logic [7:0]  led_out;
    logic [7:0]  led_sel;
    logic [31:0] digit_code;
    logic [7:0]  digit_blank;
    logic [7:0]  digit_err;
    logic [7:0]  digit_dp;
    logic        frame_done;
    logic        sel_err;

    modport master (
        output led_out, led_sel,
        input  digit_code, digit_blank, digit_err, digit_dp, frame_done, sel_err
    );

    modport slave (
        input  led_out, led_sel,
        output digit_code, digit_blank, digit_err, digit_dp, frame_done, sel_err
    );
endinterface

// File: rtl/led_scan_capture.sv
// led_scan_capture
// Rebuilds the content of an 8-digit multiplexed seven-segment display from
// its segment and digit-select buses.
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : led_scan_capture_if.slave (display buses in, digit fields and pulses out)
// Parameter SETTLE (1..255): cycles a synchronized select must stay unchanged
// before the segment bus is sampled.
module led_scan_capture #(
    parameter int unsigned SETTLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    led_scan_capture_if.slave  bus
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    logic [7:0]  out_meta_q, out_sync_q;
    logic [7:0]  sel_meta_q, sel_sync_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        taken_q, taken_d;
    logic [31:0] code_q, code_d;
    logic [7:0]  blank_q, blank_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  seen_q, seen_d;
    logic        frame_q, frame_d;
    logic        sel_err_q, sel_err_d;

    logic        sel_change;
    logic        sample;
    logic [6:0]  seg_hi;
    logic [3:0]  dec_nib;
    logic        dec_hex;
    logic [7:0]  seen_nxt;

    // Comparing the two synchronizer stages flags a select change one cycle
    // before it reaches s_sel; because the counter is registered, cnt_q then
    // reads 0 on the first cycle s_sel holds the new value.
    assign sel_change = (sel_meta_q != sel_sync_q);
    assign sample     = (cnt_q == SETTLE_C) && !taken_q;
    assign seg_hi     = ~out_sync_q[6:0];

    always_comb begin
        dec_hex = 1'b1;
        dec_nib = 4'h0;
        case (seg_hi)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_hex = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        taken_d   = taken_q;
        code_d    = code_q;
        blank_d   = blank_q;
        err_d     = err_q;
        dp_d      = dp_q;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        sel_err_d = 1'b0;
        seen_nxt  = seen_q;

        if (sel_change) begin
            cnt_d = 8'd0;
        end else if (cnt_q != SETTLE_C) begin
            cnt_d = cnt_q + 8'd1;
        end

        // A change arriving on the sample cycle still lets the old, stable
        // window be sampled, but opens the next window un-taken.
        if (sel_change) begin
            taken_d = 1'b0;
        end else if (sample) begin
            taken_d = 1'b1;
        end

        if (sample && (sel_sync_q != 8'hFF)) begin
            if ($onehot(~sel_sync_q)) begin
                for (int i = 0; i < 8; i++) begin
                    if (!sel_sync_q[i]) begin
                        code_d[4*i +: 4] = dec_hex ? dec_nib : 4'h0;
                        blank_d[i]       = !dec_hex && (seg_hi == 7'h00);
                        err_d[i]         = !dec_hex && (seg_hi != 7'h00);
                        dp_d[i]          = ~out_sync_q[7];
                        seen_nxt[i]      = 1'b1;
                    end
                end
                if (seen_nxt == 8'hFF) begin
                    frame_d = 1'b1;
                    seen_d  = 8'h00;
                end else begin
                    seen_d  = seen_nxt;
                end
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_meta_q <= 8'hFF;
            out_sync_q <= 8'hFF;
            sel_meta_q <= 8'hFF;
            sel_sync_q <= 8'hFF;
            cnt_q      <= 8'd0;
            taken_q    <= 1'b0;
            code_q     <= 32'h0;
            blank_q    <= 8'h00;
            err_q      <= 8'h00;
            dp_q       <= 8'h00;
            seen_q     <= 8'h00;
            frame_q    <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            out_meta_q <= bus.led_out;
            out_sync_q <= out_meta_q;
            sel_meta_q <= bus.led_sel;
            sel_sync_q <= sel_meta_q;
            cnt_q      <= cnt_d;
            taken_q    <= taken_d;
            code_q     <= code_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            dp_q       <= dp_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.digit_code  = code_q;
    assign bus.digit_blank = blank_q;
    assign bus.digit_err   = err_q;
    assign bus.digit_dp    = dp_q;
    assign bus.frame_done  = frame_q;
    assign bus.sel_err     = sel_err_q;

endmodule

// File: tb/tb_led_scan_capture.sv
// tb_led_scan_capture
// Drives directed scan sequences into led_scan_capture. Expected frame_done /
// sel_err pulses (with the cycle they must appear and the field contents at
// that moment) are queued as stimulus is issued; a monitor pops and compares
// on every pulse. Direct checks cover reset and field contents between scans.
module tb_led_scan_capture;

    localparam int SETTLE = 4;

    typedef struct {
        logic [1:0]  kind;   // 2'b10 frame_done, 2'b01 sel_err
        int          cyc;
        logic [31:0] code;
        logic [7:0]  blank;
        logic [7:0]  err;
        logic [7:0]  dp;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    ev_t  sb[$];

    logic [31:0] exp_code;
    logic [7:0]  exp_blank, exp_err, exp_dp, exp_seen;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    led_scan_capture_if bus ();

    led_scan_capture #(.SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour of one sampled stable select window.
    task automatic model_sample(input logic [7:0] sel, input logic [6:0] seg,
                                input logic dp, input int t);
        int   zeros;
        int   idx;
        int   nib;
        ev_t  e;
        zeros = 0;
        idx   = 0;
        for (int k = 0; k < 8; k++) begin
            if (!sel[k]) begin
                zeros++;
                idx = k;
            end
        end
        if (zeros == 1) begin
            nib = -1;
            for (int j = 0; j < 16; j++) begin
                if (seg_tab[j] == seg) nib = j;
            end
            exp_code[4*idx +: 4] = (nib >= 0) ? 4'(nib) : 4'h0;
            exp_blank[idx]       = (nib < 0) && (seg == 7'h00);
            exp_err[idx]         = (nib < 0) && (seg != 7'h00);
            exp_dp[idx]          = dp;
            exp_seen[idx]        = 1'b1;
            if (exp_seen == 8'hFF) begin
                exp_seen = 8'h00;
                e = '{kind: 2'b10, cyc: t + SETTLE + 3, code: exp_code,
                      blank: exp_blank, err: exp_err, dp: exp_dp};
                sb.push_back(e);
            end
        end else if (zeros > 1) begin
            e = '{kind: 2'b01, cyc: t + SETTLE + 3, code: exp_code,
                  blank: exp_blank, err: exp_err, dp: exp_dp};
            sb.push_back(e);
        end
    endtask

    // Pins change 1 time unit after a rising edge and are held 'hold' cycles.
    task automatic drive(input logic [7:0] sel, input logic [6:0] seg,
                         input logic dp, input int hold);
        @(posedge clk);
        #1;
        bus.led_sel = sel;
        bus.led_out = {~dp, ~seg};
        if (hold >= SETTLE + 1 && sel != 8'hFF) model_sample(sel, seg, dp, cyc);
        repeat (hold - 1) @(posedge clk);
    endtask

    function automatic logic [7:0] dsel(input int d);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << d);
    endfunction

    task automatic model_reset();
        exp_code  = 32'h0;
        exp_blank = 8'h00;
        exp_err   = 8'h00;
        exp_dp    = 8'h00;
        exp_seen  = 8'h00;
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.frame_done || bus.sel_err)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got frame_done=%0b sel_err=%0b at cycle %0d required none",
                         bus.frame_done, bus.sel_err, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("pulse_kind",  {30'd0, bus.frame_done, bus.sel_err}, {30'd0, e.kind});
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_code",  bus.digit_code, e.code);
                check("pulse_blank", {24'd0, bus.digit_blank}, {24'd0, e.blank});
                check("pulse_err",   {24'd0, bus.digit_err},   {24'd0, e.err});
                check("pulse_dp",    {24'd0, bus.digit_dp},    {24'd0, e.dp});
            end
        end
    end

    int gl [8] = '{0, 1, 2, 3, 10, 11, 14, 15};

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.led_sel = 8'hFF;
        bus.led_out = 8'hFF;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_code",  bus.digit_code, 32'h0);
        check("reset_blank", {24'd0, bus.digit_blank}, 32'h0);
        check("reset_err",   {24'd0, bus.digit_err}, 32'h0);
        check("reset_dp",    {24'd0, bus.digit_dp}, 32'h0);
        check("reset_pulses", {30'd0, bus.frame_done, bus.sel_err}, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Normal scan: glyphs 0,1,2,3,A,b,E,F with dp on digit 3.
        for (int d = 0; d < 8; d++) drive(dsel(d), seg_tab[gl[d]], (d == 3), 20);
        drive(8'hFF, 7'h00, 1'b0, 10);
        check("scan_code",  bus.digit_code, 32'hFEBA_3210);
        check("scan_dp",    {24'd0, bus.digit_dp}, 32'h08);
        check("scan_blank", {24'd0, bus.digit_blank}, 32'h0);
        check("scan_err",   {24'd0, bus.digit_err}, 32'h0);

        // Glitch: digit 0 select for only 3 cycles must not be captured.
        drive(dsel(0), seg_tab[8], 1'b0, 3);
        drive(8'hFF, 7'h00, 1'b0, 10);
        check("glitch_code", bus.digit_code, 32'hFEBA_3210);

        // Bad select pattern: a single sel_err pulse, no capture.
        drive(8'b1111_0011, seg_tab[5], 1'b0, 10);
        drive(8'hFF, 7'h00, 1'b0, 10);
        check("badsel_code", bus.digit_code, 32'hFEBA_3210);

        // Blank glyph on digit 5, non-hex glyph on digit 6.
        drive(dsel(5), 7'h00, 1'b0, 20);
        drive(dsel(6), 7'h01, 1'b0, 20);
        drive(8'hFF, 7'h00, 1'b0, 10);
        check("blank5", {31'd0, bus.digit_blank[5]}, 32'd1);
        check("err6",   {31'd0, bus.digit_err[6]}, 32'd1);
        check("blankerr_code", bus.digit_code, 32'hF00A_3210);
        check("blankerr_flags", {16'd0, bus.digit_blank, bus.digit_err}, 32'h0000_2040);

        // Partial frame, then asynchronous reset in the middle of a window.
        drive(dsel(7), seg_tab[1], 1'b0, 20);
        drive(dsel(0), seg_tab[2], 1'b0, 20);
        drive(dsel(1), seg_tab[3], 1'b0, 20);
        drive(dsel(2), seg_tab[4], 1'b1, 12);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_code",  bus.digit_code, 32'h0);
        check("async_blank", {24'd0, bus.digit_blank}, 32'h0);
        check("async_err",   {24'd0, bus.digit_err}, 32'h0);
        check("async_dp",    {24'd0, bus.digit_dp}, 32'h0);
        check("async_pulses", {30'd0, bus.frame_done, bus.sel_err}, 32'h0);
        bus.led_sel = 8'hFF;
        bus.led_out = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Fresh frame with a repeated digit 2 before digit 7.
        for (int d = 0; d < 7; d++) drive(dsel(d), seg_tab[d + 5], 1'b0, 20);
        drive(dsel(2), seg_tab[12], 1'b0, 20);
        drive(8'hFF, 7'h00, 1'b0, 10);
        check("repeat_nib2", {28'd0, bus.digit_code[11:8]}, 32'hC);
        check("repeat_code", bus.digit_code, 32'h0BA9_8C65);
        drive(dsel(7), seg_tab[9], 1'b0, 20);
        drive(8'hFF, 7'h00, 1'b0, 10);
        check("final_code", bus.digit_code, 32'h9BA9_8C65);

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
        check("pending_events", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
